// File: rtl/apb_txn_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_txn_arbiter_if
//   Bundles the two-requester command/response handshake and the
//   APB-master-bridge control signals used by apb_txn_arbiter.
//
//   Requester side : req_valid/req_write/req_addr/req_wdata -> req_ready,
//                    rsp_valid/rsp_err/rsp_timeout/rsp_rdata
//   Bridge side    : transfer/READ_WRITE/apb_*_paddr/apb_write_data ->
//                    PENABLE/PREADY/PSLVERR/apb_read_data_out
//
//   Modports:
//     master - the arbiter (it masters the bridge and serves the requesters)
//     slave  - the environment (requesters, bridge and slave)
// ---------------------------------------------------------------------------
interface apb_txn_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    // requester command/response, index 0 = req0, index 1 = req1
    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_valid;
    logic                   rsp_err;
    logic                   rsp_timeout;
    logic [DATA_W-1:0]      rsp_rdata;

    // bridge control
    logic                   transfer;
    logic                   READ_WRITE;
    logic [ADDR_W-1:0]      apb_write_paddr;
    logic [ADDR_W-1:0]      apb_read_paddr;
    logic [DATA_W-1:0]      apb_write_data;
    logic                   PENABLE;
    logic                   PREADY;
    logic                   PSLVERR;
    logic [DATA_W-1:0]      apb_read_data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata,
        output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        input  PENABLE, PREADY, PSLVERR, apb_read_data_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata,
        input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        output PENABLE, PREADY, PSLVERR, apb_read_data_out
    );
endinterface

// File: rtl/apb_txn_arbiter.sv
// ---------------------------------------------------------------------------
// apb_txn_arbiter
//   Two-requester round-robin arbiter/sequencer in front of an APB master
//   bridge. One command is accepted at a time, held stable on the bridge
//   inputs until the transfer completes (PREADY), errors (PSLVERR) or times
//   out, and a one-cycle response is returned to the granted requester.
//
// Ports
//   PCLK     in  clock, rising edge
//   PRESET   in  asynchronous active-high reset
//   bus      apb_txn_arbiter_if.master
//              requester side: req_valid/write/addr/wdata in, req_ready out,
//                              rsp_valid/err/timeout/rdata out
//              bridge side   : transfer/READ_WRITE/paddr/write_data out,
//                              PENABLE/PREADY/PSLVERR/read_data in
// ---------------------------------------------------------------------------
module apb_txn_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_txn_arbiter_if.master  bus
);
    localparam int              TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;
    logic               to_q, to_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               sel;
    logic [1:0]         ready;
    logic [1:0]         rsp_vld;
    logic               busy;

    // Single requester wins outright; on contention the one not served
    // last goes. With no valid the value is unused.
    always_comb sel = (&bus.req_valid) ? ~last_q : bus.req_valid[1];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;   // req0 wins the first contention
            timer_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        grant_d = grant_q;
        last_d  = last_q;
        timer_d = timer_q;
        err_d   = err_q;
        to_d    = to_q;
        rdata_d = rdata_q;
        ready   = '0;
        rsp_vld = '0;

        unique case (state_q)
            S_IDLE: begin
                // ready follows valid directly, so any valid is accepted
                // at the next edge
                if (|bus.req_valid) begin
                    ready[sel]  = 1'b1;
                    cmd_d.wr    = bus.req_write[sel];
                    cmd_d.addr  = bus.req_addr[sel];
                    cmd_d.wdata = bus.req_wdata[sel];
                    grant_d     = sel;
                    timer_d     = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                timer_d = timer_q + TMR_W'(1);
                if (bus.PSLVERR) begin
                    err_d   = 1'b1;
                    to_d    = 1'b0;
                    state_d = S_DONE;
                end else if (bus.PENABLE && bus.PREADY) begin
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    if (!cmd_q.wr) rdata_d = bus.apb_read_data_out;
                    state_d = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    // timer_q counts completed BUSY cycles, so this is
                    // the TIMEOUT-th one
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rsp_vld[grant_q] = 1'b1;
                last_d           = grant_q;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bridge inputs are driven only while BUSY; dropping transfer in DONE
    // lets the bridge fall back to its idle state.
    assign busy                = (state_q == S_BUSY);
    assign bus.transfer        = busy;
    assign bus.READ_WRITE      = busy & ~cmd_q.wr;
    assign bus.apb_write_paddr = busy ? cmd_q.addr : '0;
    assign bus.apb_read_paddr  = busy ? cmd_q.addr : '0;
    assign bus.apb_write_data  = (busy && cmd_q.wr) ? cmd_q.wdata : '0;

    assign bus.req_ready       = ready;
    assign bus.rsp_valid       = rsp_vld;
    assign bus.rsp_err         = err_q;
    assign bus.rsp_timeout     = to_q;
    assign bus.rsp_rdata       = rdata_q;
endmodule
